// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and baud divider helper
// Purpose: transmitter state encoding and the clock divider function, shared by TX and a future RX.
// Ports: none (package).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Sysclk cycles per bit time, truncated.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - synchronous FIFO with registered read data
// Purpose: DEPTH x WIDTH queue; rd_data is loaded on the edge that pops.
// Ports: clk, rst (sync, active-high), push/push_data, pop, rd_data, count, full, empty.
module uart_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is accepted only when the same edge frees a slot.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter fed by a synchronous FIFO
// Purpose: serialises queued words LSB-first: start, DATA_BITS data, optional parity, stop bits.
// Ports: sysclk, cpu_reset (sync, active-high), wr_data/wr_valid/wr_ready write port,
//   fifo_count (queued words), busy, uart_tx (idle high), par_odd (only with UART_TX_PARITY_EN).
// Macro: UART_TX_PARITY_EN adds a parity bit after the data bits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          sysclk,
  input  logic                          cpu_reset,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          uart_tx
`ifdef UART_TX_PARITY_EN
  ,
  input  logic                          par_odd
`endif
);

  localparam int unsigned DIV = baud_div(CLK_HZ, BAUD);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BW  = $clog2(DATA_BITS);

  tx_state_t            state;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 load_pending;
  logic                 tick;
  logic                 pop;
  logic                 push;
  logic                 line_next;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rd_data;
`ifdef UART_TX_PARITY_EN
  logic                 par_odd_q;
  logic                 par_bit;
`endif

  assign wr_ready = ~fifo_full;
  assign push     = wr_valid & wr_ready;
  assign tick     = (baud_cnt == CW'(DIV - 1));
  assign pop      = ~fifo_empty &
                    ((state == IDLE) ||
                     (state == STOP && tick && bit_cnt == BW'(STOP_BITS - 1)));

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (sysclk),
    .rst       (cpu_reset),
    .push      (push),
    .push_data (wr_data),
    .pop       (pop),
    .rd_data   (fifo_rd_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    line_next = 1'b1;
    case (state)
      START:   line_next = 1'b0;
      DATA:    line_next = shreg[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  line_next = par_bit;
`endif
      default: line_next = 1'b1;
    endcase
  end

  // The line and busy are registered from the current state, so both trail the FSM by one
  // cycle; the popped word reaches the shift register one cycle into START, well before DATA.
  always_ff @(posedge sysclk) begin
    if (cpu_reset) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      load_pending <= 1'b0;
      uart_tx      <= 1'b1;
      busy         <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_odd_q    <= 1'b0;
      par_bit      <= 1'b0;
`endif
    end else begin
      uart_tx      <= line_next;
      busy         <= (state != IDLE) | (fifo_count != '0);
      load_pending <= pop;
      if (load_pending) begin
        shreg <= fifo_rd_data;
`ifdef UART_TX_PARITY_EN
        par_bit <= (^fifo_rd_data) ^ par_odd_q;
`endif
      end
`ifdef UART_TX_PARITY_EN
      if (pop) begin
        par_odd_q <= par_odd;
      end
`endif
      if (state == IDLE || tick) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (!fifo_empty) begin
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            shreg <= shreg >> 1;
            if (bit_cnt == BW'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state   <= STOP;
            bit_cnt <= '0;
          end
        end
        STOP: begin
          if (tick) begin
            if (bit_cnt == BW'(STOP_BITS - 1)) begin
              bit_cnt <= '0;
              state   <= fifo_empty ? IDLE : START;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with a serial-line scoreboard
module tb_uart_tx_fifo;

  localparam int DIV = 16;

  logic       sysclk = 1'b0;
  logic       cpu_reset;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] fifo_count;
  logic       busy;
  logic       uart_tx;
`ifdef UART_TX_PARITY_EN
  logic       par_odd;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int max_count = 0;
  logic [8:0] sb_q[$];
  int start_q[$];

  uart_tx_fifo #(
    .CLK_HZ     (16),
    .BAUD       (1),
    .DATA_BITS  (8),
    .STOP_BITS  (1),
    .FIFO_DEPTH (4)
  ) dut (
    .sysclk     (sysclk),
    .cpu_reset  (cpu_reset),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .fifo_count (fifo_count),
    .busy       (busy),
    .uart_tx    (uart_tx)
`ifdef UART_TX_PARITY_EN
    ,
    .par_odd    (par_odd)
`endif
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  always @(negedge sysclk) begin
    if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Serial sampler: mid-bit sampling of each frame, compared against the scoreboard head.
  task automatic wait_cycles(input int n, inout bit aborted);
    for (int i = 0; i < n && !aborted; i++) begin
      @(negedge sysclk);
      if (cpu_reset) aborted = 1'b1;
    end
  endtask

  task automatic sample_frame();
    bit         ab;
    logic [7:0] d;
    logic       par;
    logic       stp;
    logic [8:0] exp_e;
    ab = 1'b0;
    par = 1'b0;
    start_q.push_back(cyc);
    wait_cycles(DIV / 2 - 1, ab);
    for (int i = 0; i < 8; i++) begin
      wait_cycles(DIV, ab);
      d[i] = uart_tx;
    end
`ifdef UART_TX_PARITY_EN
    wait_cycles(DIV, ab);
    par = uart_tx;
`endif
    wait_cycles(DIV, ab);
    stp = uart_tx;
    if (!ab) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sampler_unexpected_frame: got data 0x%02h, required no frame", d);
      end else begin
        exp_e = sb_q.pop_front();
        if (d !== exp_e[7:0]) begin
          errors++;
          $display("FAIL sampler_data: got 0x%02h, required 0x%02h", d, exp_e[7:0]);
        end
`ifdef UART_TX_PARITY_EN
        checks++;
        if (par !== exp_e[8]) begin
          errors++;
          $display("FAIL sampler_parity: got %0b, required %0b", par, exp_e[8]);
        end
`endif
      end
      checks++;
      if (stp !== 1'b1) begin
        errors++;
        $display("FAIL sampler_stop: got %0b, required 1", stp);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge sysclk);
      if (!cpu_reset && uart_tx === 1'b0) sample_frame();
    end
  end

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push_byte(input logic [7:0] d, output int acc_cyc);
    int   n;
    logic pexp;
    pexp = 1'b0;
`ifdef UART_TX_PARITY_EN
    pexp = (^d) ^ par_odd;
`endif
    wr_data  = d;
    wr_valid = 1'b1;
    n = 0;
    while (wr_ready !== 1'b1 && n < 500) begin
      @(negedge sysclk);
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL push_timeout: wr_ready=%0b after %0d cycles, required 1", wr_ready, n);
      wr_valid = 1'b0;
      acc_cyc = -1;
    end else begin
      @(posedge sysclk);
      #1 acc_cyc = cyc;
      sb_q.push_back({pexp, d});
      @(negedge sysclk);
      wr_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int limit, output int done_cyc);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge sysclk);
      n++;
    end
    done_cyc = cyc;
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL idle_timeout: busy=%0b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic check_sb_empty(input string name);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s_sb_empty: %0d frames missing, required 0", name, sb_q.size());
    end
  endtask

  task automatic test_reset();
    cpu_reset = 1'b1;
    wr_valid  = 1'b0;
    wr_data   = 8'h00;
`ifdef UART_TX_PARITY_EN
    par_odd   = 1'b0;
`endif
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    cpu_reset = 1'b0;
    checks += 4;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %0b, required 1", uart_tx); end
    if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b, required 1", wr_ready); end
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d, required 0", fifo_count); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b, required 0", busy); end
  endtask

  task automatic test_single_frame();
    int cp, fall, rise, bz, n;
    push_byte(8'h55, cp);
    n = 0;
    while (uart_tx !== 1'b0 && n < 20) begin @(negedge sysclk); n++; end
    fall = cyc;
    checks++;
    if (fall - cp != 2) begin errors++; $display("FAIL single_latency: got %0d, required 2", fall - cp); end
    n = 0;
    while (uart_tx !== 1'b1 && n < 40) begin @(negedge sysclk); n++; end
    rise = cyc;
    checks++;
    if (rise - fall != DIV) begin errors++; $display("FAIL single_start_len: got %0d, required %0d", rise - fall, DIV); end
    wait_idle(400, bz);
    checks++;
    if (bz - cp != 162) begin errors++; $display("FAIL single_busy_fall: got %0d, required 162", bz - cp); end
    check_sb_empty("single");
  endtask

  task automatic test_back_to_back();
    int c0, c1, bz;
    start_q.delete();
    push_byte(8'hA3, c0);
    push_byte(8'h0F, c1);
    wait_idle(600, bz);
    checks++;
    if (start_q.size() != 2) begin
      errors++;
      $display("FAIL b2b_frames: got %0d, required 2", start_q.size());
    end else begin
      checks++;
      if (start_q[1] - start_q[0] != 160) begin
        errors++;
        $display("FAIL b2b_gap: got %0d, required 160", start_q[1] - start_q[0]);
      end
    end
    check_sb_empty("b2b");
  endtask

  task automatic test_fill();
    int acc[5];
    logic [7:0] vals[5];
    int bz;
    vals[0] = 8'h01; vals[1] = 8'h82; vals[2] = 8'hC3; vals[3] = 8'h3C; vals[4] = 8'hE7;
    max_count = 0;
    for (int i = 0; i < 5; i++) push_byte(vals[i], acc[i]);
    checks++;
    if (acc[4] - acc[0] != 4) begin errors++; $display("FAIL fill_accept_span: got %0d, required 4", acc[4] - acc[0]); end
    checks += 2;
    if (fifo_count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d, required 4", fifo_count); end
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %0b, required 0", wr_ready); end
    wait_idle(1200, bz);
    checks++;
    if (max_count != 4) begin errors++; $display("FAIL fill_max_count: got %0d, required 4", max_count); end
    check_sb_empty("fill");
  endtask

  task automatic test_reset_mid_frame();
    int cp, tmp, n, lows;
    push_byte(8'hFF, cp);
    push_byte(8'h12, tmp);
    push_byte(8'h34, tmp);
    n = 0;
    while (cyc - cp < 2 + DIV * 4 + DIV / 2 && n < 200) begin @(negedge sysclk); n++; end
    cpu_reset = 1'b1;
    @(posedge sysclk);
    #1;
    checks += 3;
    if (uart_tx !== 1'b1) begin errors++; $display("FAIL midreset_tx: got %0b, required 1", uart_tx); end
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL midreset_count: got %0d, required 0", fifo_count); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %0b, required 0", busy); end
    @(negedge sysclk);
    @(negedge sysclk);
    cpu_reset = 1'b0;
    sb_q.delete();
    lows = 0;
    repeat (400) begin
      @(negedge sysclk);
      if (uart_tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    checks++;
    if (lows != 0) begin errors++; $display("FAIL midreset_quiet: %0d active cycles, required 0", lows); end
  endtask

  task automatic test_full_push_pop();
    int a0, tmp, a5, bz;
    max_count = 0;
    push_byte(8'h11, a0);
    push_byte(8'h21, tmp);
    push_byte(8'h31, tmp);
    push_byte(8'h41, tmp);
    push_byte(8'h51, tmp);
    checks++;
    if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count_before: got %0d, required 4", fifo_count); end
    push_byte(8'h99, a5);
    checks += 2;
    if (a5 - a0 != 162) begin errors++; $display("FAIL full_accept_cycle: got %0d, required 162", a5 - a0); end
    if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count_after: got %0d, required 4", fifo_count); end
    wait_idle(1400, bz);
    checks++;
    if (max_count > 4) begin errors++; $display("FAIL full_max_count: got %0d, required <=4", max_count); end
    check_sb_empty("full");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int cp, bz;
    par_odd = 1'b0;
    push_byte(8'h07, cp);
    wait_idle(400, bz);
    checks++;
    if (bz - cp - 2 != 176) begin errors++; $display("FAIL parity_frame_len: got %0d, required 176", bz - cp - 2); end
    par_odd = 1'b1;
    push_byte(8'h07, cp);
    wait_idle(400, bz);
    check_sb_empty("parity");
    par_odd = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_fill();
    test_reset_mid_frame();
    test_full_push_pop();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    repeat (4) @(negedge sysclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
